sram_port_arbiter: RTL and testbench

- Shares the single external SRAM (16-bit address, 8-bit data) between two requesters.
- Port A is the encryptor datapath: address generator plus input/output byte units. Port B is a host/loader port used for bulk preload and readback.
- Arbitration is round-robin with a burst limit. Read data is returned to the port that issued the read, using a tag pipeline matched to the SRAM read latency.

---
 rtl/sram_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between port A (encryptor
// datapath) and port B (host/loader). Round-robin ownership with a burst
// limit; read data is steered back to the issuing port through a tag pipeline
// whose depth matches the SRAM read latency.
//
// Handshake: a port raises x_req and holds its fields until accepted. A cycle
// with x_gnt==1 and x_req==1 is an access; that cycle counts as accepted and
// the port may present new fields (or drop x_req) on the next cycle. Reads
// return on a one-cycle x_rvalid pulse RD_LAT+1 cycles after the access.
//
// Optional build macro: SRAM_ARB_STATS_EN enables the saturating per-port
// access counters a_count / b_count; without it both read as zero.
//
// fsm_state exposes the arbiter state (0 IDLE, 1 OWN_A, 2 OWN_B) for debug.
module sram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              sram_w_en,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [15:0]       a_count,
  output logic [15:0]       b_count,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t          state, state_nxt;
  logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
  logic            last_owner, last_owner_nxt;   // 0 = A, 1 = B
  logic            acc_a, acc_b, burst_last;
  logic [RD_LAT-1:0] tag_v, tag_b;               // valid and owner (1 = B) per stage
  logic            ret_v, ret_b;

  assign acc_a      = (state == OWN_A) && a_req;
  assign acc_b      = (state == OWN_B) && b_req;
  assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));
  assign fsm_state  = state;

  // State, burst counter and last owner registers
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Next-state: round-robin on ties, hand over after MAX_BURST accesses if the other port waits
  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (a_req && b_req) state_nxt = last_owner ? OWN_A : OWN_B;
        else if (a_req)     state_nxt = OWN_A;
        else if (b_req)     state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!a_req) begin
          burst_cnt_nxt  = '0;
          last_owner_nxt = 1'b0;
          state_nxt      = b_req ? OWN_B : IDLE;
        end else if (burst_last) begin
          burst_cnt_nxt = '0;
          if (b_req) begin
            state_nxt      = OWN_B;
            last_owner_nxt = 1'b0;
          end
        end else begin
          burst_cnt_nxt = burst_cnt + BW'(1);
        end
      end
      OWN_B: begin
        if (!b_req) begin
          burst_cnt_nxt  = '0;
          last_owner_nxt = 1'b1;
          state_nxt      = a_req ? OWN_A : IDLE;
        end else if (burst_last) begin
          burst_cnt_nxt = '0;
          if (a_req) begin
            state_nxt      = OWN_A;
            last_owner_nxt = 1'b1;
          end
        end else begin
          burst_cnt_nxt = burst_cnt + BW'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs: grants decoded from state, SRAM pins driven from the owner during an access
  always_comb begin
    a_gnt      = (state == OWN_A);
    b_gnt      = (state == OWN_B);
    sram_w_en  = 1'b0;
    sram_r_en  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (acc_a) begin
      sram_w_en  = a_we;
      sram_r_en  = ~a_we;
      sram_addr  = a_addr;
      sram_wdata = a_wdata;
    end else if (acc_b) begin
      sram_w_en  = b_we;
      sram_r_en  = ~b_we;
      sram_addr  = b_addr;
      sram_wdata = b_wdata;
    end
  end

  // Read tag pipeline: one stage per cycle of SRAM read latency
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      tag_v <= '0;
      tag_b <= '0;
    end else begin
      tag_v[0] <= sram_r_en;
      tag_b[0] <= acc_b;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
      end
    end
  end

  assign ret_v = tag_v[RD_LAT-1];
  assign ret_b = tag_b[RD_LAT-1];

  // Capture returning read data into the issuing port and pulse its rvalid
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= ret_v && !ret_b;
      b_rvalid <= ret_v && ret_b;
      if (ret_v && !ret_b) a_rdata <= sram_rdata;
      if (ret_v && ret_b)  b_rdata <= sram_rdata;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Saturating per-port access counters
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (acc_a && (a_count != 16'hFFFF)) a_count <= a_count + 16'd1;
      if (acc_b && (b_count != 16'hFFFF)) b_count <= b_count + 16'd1;
    end
  end
`else
  assign a_count = '0;
  assign b_count = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios followed by randomized traffic on
// both ports, checked every cycle against a behavioural arbiter/memory model.
module tb_sram_port_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 8;
  localparam int EW        = 32 + 1 + DATA_W;   // {due cycle, port (1=B), data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              sram_w_en, sram_r_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic [15:0]       a_count, b_count;
  logic [1:0]        dbg_state;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .a_count(a_count), .b_count(b_count), .fsm_state(dbg_state)
  );

  // ---------------- SRAM model (driven from DUT pins) ----------------
  logic [DATA_W-1:0] sram_mem [0:65535];
  logic [DATA_W-1:0] rd_pipe  [0:RD_LAT-1];
  logic              s_we = 1'b0, s_re = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_wdata = '0;
  assign sram_rdata = rd_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [EW-1:0]     exp_q[$];
  int                cyc = 0;
  int                m_own;          // 0 nobody, 1 A, 2 B
  int                m_last;         // 1 A, 2 B
  int                m_run;          // accesses in the current ownership run
  bit                acc_a_q, acc_b_q, cur_rv_a, cur_rv_b;
  logic [DATA_W-1:0] m_rdata_a, m_rdata_b;
  logic [15:0]       m_cnt_a, m_cnt_b;
  bit                run_chk = 1'b0;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    m_own = 0; m_last = 2; m_run = 0;
    exp_q.delete();
    acc_a_q = 0; acc_b_q = 0; cur_rv_a = 0; cur_rv_b = 0;
    m_rdata_a = '0; m_rdata_b = '0; m_cnt_a = '0; m_cnt_b = '0;
  endtask

  task automatic do_access(input bit port_b, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    if (we) ref_mem[addr] = wd;
    else    exp_q.push_back({32'(cyc + RD_LAT + 1), port_b, ref_mem[addr]});
`ifdef SRAM_ARB_STATS_EN
    if (!port_b && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
    if (port_b  && m_cnt_b != 16'hFFFF) m_cnt_b = m_cnt_b + 16'd1;
`endif
  endtask

  // Apply the cycle that just ended (inputs still hold that cycle's values).
  task automatic model_step();
    bit a_acc, b_acc, own_req, oth_req;
    logic [EW-1:0] e;
    if (n_rst) begin
      reset_model();
      cyc++;
      return;
    end
    a_acc = (m_own == 1) && a_req;
    b_acc = (m_own == 2) && b_req;
    if (a_acc) do_access(1'b0, a_we, a_addr, a_wdata);
    if (b_acc) do_access(1'b1, b_we, b_addr, b_wdata);
    acc_a_q = a_acc; acc_b_q = b_acc;
    if (m_own == 0) begin
      m_run = 0;
      if (a_req && b_req) m_own = (m_last == 2) ? 1 : 2;
      else if (a_req)     m_own = 1;
      else if (b_req)     m_own = 2;
    end else begin
      own_req = (m_own == 1) ? a_req : b_req;
      oth_req = (m_own == 1) ? b_req : a_req;
      if (!own_req) begin
        m_last = m_own;
        m_own  = oth_req ? 3 - m_own : 0;
        m_run  = 0;
      end else begin
        m_run++;
        if (m_run == MAX_BURST) begin
          m_run = 0;
          if (oth_req) begin
            m_last = m_own;
            m_own  = 3 - m_own;
          end
        end
      end
    end
    cyc++;
    cur_rv_a = 0; cur_rv_b = 0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (e[EW-1 -: 32] == 32'(cyc)) begin
        void'(exp_q.pop_front());
        if (e[DATA_W]) begin cur_rv_b = 1; m_rdata_b = e[DATA_W-1:0]; end
        else           begin cur_rv_a = 1; m_rdata_a = e[DATA_W-1:0]; end
      end
    end
  endtask

  task automatic sram_step();
    logic [DATA_W-1:0] rd;
    rd = s_re ? sram_mem[s_addr] : '0;
    if (s_we) sram_mem[s_addr] = s_wdata;
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    sram_step();
  endtask

  // Assert reset for one cycle (asynchronously, mid-cycle) and release it.
  task automatic do_reset();
    n_rst = 1'b1;
    reset_model();
    @(negedge clk);
    chk("rst_gnt",    32'(a_gnt | b_gnt), 32'd0);
    chk("rst_sram",   32'(sram_w_en | sram_r_en | (|sram_addr)), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid | b_rvalid), 32'd0);
    chk("rst_rdata",  32'({a_rdata, b_rdata}), 32'd0);
    step();
    n_rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_rand(input int pa, input int pb);
    if (!a_req || acc_a_q) begin
      a_req   = ($urandom_range(0, 99) < 32'(pa));
      a_we    = 1'($urandom_range(0, 1));
      a_addr  = 16'($urandom_range(0, 15));
      a_wdata = 8'($urandom_range(0, 255));
    end
    if (!b_req || acc_b_q) begin
      b_req   = ($urandom_range(0, 99) < 32'(pb));
      b_we    = 1'($urandom_range(0, 1));
      b_addr  = 16'($urandom_range(0, 15));
      b_wdata = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- per-cycle compare ----------------
  // Mid-cycle: check every DUT output against the model and latch SRAM pins for the memory.
  always @(negedge clk) begin
    bit ea, eb;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    s_we = sram_w_en; s_re = sram_r_en; s_addr = sram_addr; s_wdata = sram_wdata;
    if (run_chk) begin
      ea = (m_own == 1) && a_req;
      eb = (m_own == 2) && b_req;
      e_addr = ea ? a_addr  : (eb ? b_addr  : '0);
      e_wd   = ea ? a_wdata : (eb ? b_wdata : '0);
      chk("a_gnt",      32'(a_gnt),      32'(m_own == 1));
      chk("b_gnt",      32'(b_gnt),      32'(m_own == 2));
      chk("sram_w_en",  32'(sram_w_en),  32'((ea && a_we) || (eb && b_we)));
      chk("sram_r_en",  32'(sram_r_en),  32'((ea && !a_we) || (eb && !b_we)));
      chk("sram_addr",  32'(sram_addr),  32'(e_addr));
      chk("sram_wdata", 32'(sram_wdata), 32'(e_wd));
      chk("a_rvalid",   32'(a_rvalid),   32'(cur_rv_a));
      chk("b_rvalid",   32'(b_rvalid),   32'(cur_rv_b));
      chk("a_rdata",    32'(a_rdata),    32'(m_rdata_a));
      chk("b_rdata",    32'(b_rdata),    32'(m_rdata_b));
      chk("a_count",    32'(a_count),    32'(m_cnt_a));
      chk("b_count",    32'(b_count),    32'(m_cnt_b));
      chk("state_legal", 32'(dbg_state != 2'd3), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    reset_model();
    run_chk = 1'b1;
    step();
    step();
    n_rst = 1'b0;

    // A writes 0x5A to 0x0010 then reads it back
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 8'h5A;
    @(negedge clk); chk("t1_gnt_delay", 32'(a_gnt), 32'd0);
    step();
    @(negedge clk);
    chk("t1_gnt", 32'(a_gnt), 32'd1);
    chk("t1_wen", 32'(sram_w_en), 32'd1);
    chk("t1_addr", 32'(sram_addr), 32'h0010);
    chk("t1_wdata", 32'(sram_wdata), 32'h5A);
    step();
    a_we = 0;
    @(negedge clk); chk("t1_ren", 32'(sram_r_en), 32'd1);
    step();
    a_req = 0;
    @(negedge clk); chk("t1_rv_early", 32'(a_rvalid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_rdata", 32'(a_rdata), 32'h5A);
    step();

    // Both request continuously: 8 A accesses, 8 B reads of 0x0003, then A again
    do_reset();
    a_req = 1; a_we = 1; a_addr = 16'h0020; a_wdata = 8'h00;
    b_req = 1; b_we = 0; b_addr = 16'h0003;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      chk("t2_a_gnt", 32'(a_gnt), 32'((k >= 1 && k <= 8) || k >= 17));
      chk("t2_b_gnt", 32'(b_gnt), 32'(k >= 9 && k <= 16));
      if (k == 18) begin
        chk("t2_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("t2_b_rdata",  32'(b_rdata),  32'h18);
        chk("t2_a_rvalid", 32'(a_rvalid), 32'd0);
      end
      step();
      a_wdata = 8'(k + 1);
    end
    a_req = 0; b_req = 0;
    repeat (3) step();

    // A drops after 3 accesses with B idle; B granted later from IDLE
    a_req = 1; a_we = 1; a_addr = 16'h0040; a_wdata = 8'h11;
    @(negedge clk); chk("t4_idle", 32'(a_gnt), 32'd0);
    step();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); chk("t4_acc", 32'(a_gnt & sram_w_en), 32'd1);
      step();
      a_addr = a_addr + 16'd1;
    end
    a_req = 0;
    @(negedge clk); chk("t4_hold_noacc", 32'({a_gnt, sram_w_en}), 32'b10);
    step();
    b_req = 1; b_we = 0; b_addr = 16'h0040;
    @(negedge clk); chk("t4_idle2", 32'({a_gnt, b_gnt}), 32'd0);
    step();
    @(negedge clk); chk("t4_b_gnt", 32'({b_gnt, sram_r_en}), 32'b11);
    step();
    b_req = 0;
    repeat (3) step();

    // Reset with B reads in flight; afterwards the first tie goes to A
    a_req = 1; a_we = 0; a_addr = 16'h0005;
    step();
    step();
    a_req = 0;
    step();
    a_req = 1; b_req = 1; b_we = 0; b_addr = 16'h0006;
    @(negedge clk); chk("t5_idle", 32'({a_gnt, b_gnt}), 32'd0);
    step();
    @(negedge clk); chk("t5_tie_to_b", 32'({a_gnt, b_gnt}), 32'b01);
    step();
    step();
    do_reset();
    @(negedge clk); chk("t5_no_rv", 32'({a_rvalid, b_rvalid, a_gnt}), 32'd0);
    step();
    @(negedge clk);
    chk("t5_first_a", 32'({a_gnt, b_gnt}), 32'b10);
    chk("t5_no_rv2", 32'(b_rvalid), 32'd0);
    step();

    // Statistics: 5 A writes, 3 B reads
    a_req = 0; b_req = 0;
    do_reset();
    a_req = 1; a_we = 1; a_addr = 16'h0080;
    step();
    repeat (5) step();
    a_req = 0; b_req = 1; b_we = 0; b_addr = 16'h0080;
    step();
    repeat (3) step();
    b_req = 0;
    @(negedge clk);
`ifdef SRAM_ARB_STATS_EN
    chk("t6_a_count", 32'(a_count), 32'd5);
    chk("t6_b_count", 32'(b_count), 32'd3);
`else
    chk("t6_a_count", 32'(a_count), 32'd0);
    chk("t6_b_count", 32'(b_count), 32'd0);
`endif
    step();

    // Randomized traffic with varying request densities and occasional resets
    for (int ph = 0; ph < 6; ph++) begin
      int pa, pb;
      pa = (ph == 0) ? 95 : (ph == 1) ? 50 : (ph == 2) ? 20 : (ph == 3) ? 95 : (ph == 4) ? 70 : 10;
      pb = (ph == 0) ? 95 : (ph == 1) ? 50 : (ph == 2) ? 80 : (ph == 3) ? 15 : (ph == 4) ? 70 : 90;
      for (int i = 0; i < 500; i++) begin
        drive_rand(pa, pb);
        if ($urandom_range(0, 299) == 0) do_reset();
        else step();
      end
    end

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
